// File: rtl/decoder_3to8_strobe.sv
// Handshaked 3-to-8 one-hot decoder that holds each strobe for HOLD_CYCLES.
// Also keeps a wrapping count of accepted codes.
module decoder_3to8_strobe #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       din,
  output logic [7:0]       dout,
  output logic             out_valid,
  output logic             busy,
  output logic [CNT_W-1:0] accept_count
);

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  state_t           state_q, state_d;
  logic [7:0]       hold_cnt_q, hold_cnt_d;
  logic [7:0]       dout_q, dout_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       accept;
  logic       load;
  logic       stop;
  logic [7:0] onehot;

  assign in_ready = enable &&
                    (state_q == IDLE || hold_cnt_q == 8'd0);
  assign accept   = in_valid && in_ready;
  assign onehot   = 8'b1 << din;

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    dout_d      = dout_q;
    out_valid_d = out_valid_q;
    load        = 1'b0;
    stop        = 1'b0;

    // Disable wins over everything, including a pending reload.
    priority case (1'b1)
      !enable:             stop = 1'b1;
      state_q == IDLE:     load = accept;
      hold_cnt_q != 8'd0:  hold_cnt_d = hold_cnt_q - 8'd1;
      default: begin
        load = accept;
        stop = !accept;
      end
    endcase

    if (load) begin
      state_d     = HOLD;
      hold_cnt_d  = HOLD_LOAD;
      dout_d      = onehot;
      out_valid_d = 1'b1;
    end else if (stop) begin
      state_d     = IDLE;
      hold_cnt_d  = 8'd0;
      dout_d      = 8'h00;
      out_valid_d = 1'b0;
    end

    busy_d = (state_d == HOLD);
    cnt_d  = accept ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_cnt_q  <= 8'd0;
      dout_q      <= 8'h00;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      dout_q      <= dout_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
    end
  end

  assign dout         = dout_q;
  assign out_valid    = out_valid_q;
  assign busy         = busy_q;
  assign accept_count = cnt_q;

endmodule

// File: tb/tb_decoder_3to8_strobe.sv
// Directed bench for decoder_3to8_strobe: a HOLD_CYCLES=4 instance
// and a HOLD_CYCLES=1 instance sharing clock and reset.
module tb_decoder_3to8_strobe;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable, in_valid, in_ready;
  logic [2:0] din;
  logic [7:0] dout;
  logic       out_valid, busy;
  logic [7:0] accept_count;

  logic       enable1, in_valid1, in_ready1;
  logic [2:0] din1;
  logic [7:0] dout1;
  logic       out_valid1, busy1;
  logic [7:0] accept_count1;

  int n_vec  = 0;
  int n_miss = 0;

  logic [7:0] oh_tab [8] = '{8'h01, 8'h02, 8'h04, 8'h08,
                             8'h10, 8'h20, 8'h40, 8'h80};

  always #5 clk = ~clk;

  decoder_3to8_strobe #(.HOLD_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .in_valid(in_valid), .in_ready(in_ready), .din(din),
    .dout(dout), .out_valid(out_valid), .busy(busy),
    .accept_count(accept_count)
  );

  decoder_3to8_strobe #(.HOLD_CYCLES(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .enable(enable1),
    .in_valid(in_valid1), .in_ready(in_ready1), .din(din1),
    .dout(dout1), .out_valid(out_valid1), .busy(busy1),
    .accept_count(accept_count1)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one code from idle, then follow the strobe through its hold.
  task automatic decode_one(input logic [2:0] code,
                            input logic [7:0] exp);
    enable   = 1'b1;
    in_valid = 1'b1;
    din      = code;
    #1;
    check("rdy_idle", in_ready, 1);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("hold_dout", dout, exp);
      check("hold_ov", out_valid, 1);
      tick();
    end
    check("end_dout", dout, 8'h00);
    check("end_busy", busy, 0);
  endtask

  initial begin
    rst       = 1'b1;
    enable    = 1'b0;
    in_valid  = 1'b0;
    din       = 3'd0;
    enable1   = 1'b0;
    in_valid1 = 1'b0;
    din1      = 3'd0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_dout", dout, 8'h00);
    check("rst_ov", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_cnt", accept_count, 0);

    // Single decode of 5
    decode_one(3'd5, 8'h20);
    check("single_cnt", accept_count, 1);

    // All eight codes
    for (int c = 0; c < 8; c++) decode_one(3'(c), oh_tab[c]);
    check("map_cnt", accept_count, 9);

    // Back-to-back 0 then 7, no gap
    in_valid = 1'b1;
    din      = 3'd0;
    tick();
    din = 3'd7;
    for (int i = 0; i < 4; i++) begin
      check("b2b_dout0", dout, 8'h01);
      check("b2b_rdy0", in_ready, (i == 3));
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("b2b_dout7", dout, 8'h80);
      check("b2b_rdy7", in_ready, (i == 3));
      tick();
    end
    check("b2b_end", dout, 8'h00);
    check("b2b_cnt", accept_count, 11);

    // Enable gating
    enable   = 1'b0;
    in_valid = 1'b1;
    din      = 3'd3;
    #1;
    check("dis_rdy", in_ready, 0);
    tick();
    check("dis_dout", dout, 8'h00);
    check("dis_cnt", accept_count, 11);
    enable = 1'b1;
    din    = 3'd2;
    tick();
    in_valid = 1'b0;
    check("abort_c1", dout, 8'h04);
    tick();
    check("abort_c2", dout, 8'h04);
    enable = 1'b0;
    #1;
    check("abort_rdy", in_ready, 0);
    tick();
    check("abort_dout", dout, 8'h00);
    check("abort_busy", busy, 0);
    check("abort_ov", out_valid, 0);
    check("abort_cnt", accept_count, 12);

    // HOLD_CYCLES=1: one new code per cycle
    enable1   = 1'b1;
    in_valid1 = 1'b1;
    din1      = 3'd0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("h1_dout", dout1, oh_tab[i]);
      check("h1_rdy", in_ready1, 1);
      din1 = 3'(i + 1);
    end
    in_valid1 = 1'b0;
    tick();
    check("h1_end", dout1, 8'h00);
    check("h1_busy", busy1, 0);
    check("h1_ov", out_valid1, 0);
    check("h1_cnt", accept_count1, 8);

    // Asynchronous reset in the middle of a hold
    enable   = 1'b1;
    in_valid = 1'b1;
    din      = 3'd6;
    tick();
    in_valid = 1'b0;
    tick();
    check("pre_rst", dout, 8'h40);
    #2;
    rst = 1'b1;
    #1;
    check("arst_dout", dout, 8'h00);
    check("arst_ov", out_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_cnt", accept_count, 0);
    tick();
    rst = 1'b0;
    #1;
    check("arst_rdy", in_ready, 1);

    // 256 accepts wrap the counter
    in_valid = 1'b1;
    for (int n = 0; n < 256; n++) begin
      int w;
      din = 3'(n);
      w   = 0;
      while (!in_ready && w < 10) begin
        tick();
        w++;
      end
      if (!in_ready) check("wrap_timeout", in_ready, 1);
      if (n == 255) check("wrap_255", accept_count, 255);
      tick();
      check("wrap_dout", dout, oh_tab[n % 8]);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("wrap_cnt", accept_count, 0);
    check("wrap_idle", dout, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/decoder_3to8_strobe.md
Name: decoder_3to8_strobe

Overview:
- Sequential 3-to-8 one-hot decoder with enable. It is the return path for the team's 8:3 priority encoder.
- Accepts a 3-bit code over a valid/ready handshake and drives the matching one-hot strobe for a programmable number of cycles.
- Used to drive select lines and strobes back out of encoded control fields.
- Keeps a running count of accepted codes.

Parameters:
- HOLD_CYCLES, default 4: number of cycles each one-hot strobe stays asserted. Legal range 1..255.
- CNT_W, default 8: width of the accepted-code counter.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  block enable. Low forces idle and blocks acceptance.
- in_valid  input  1  din is valid this cycle.
- in_ready  output  1  block can accept a code this cycle (combinational).
- din  input  3  code to decode, 0..7.
- dout  output  8  registered one-hot strobe: bit din set while active, else 8'h00.
- out_valid  output  1  registered; high whenever dout is nonzero.
- busy  output  1  registered; high while in HOLD.
- accept_count  output  CNT_W  registered count of accepted codes. Wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst high, asynchronous): the following take effect immediately, independent of clk, and persist while rst is high.
  - State = IDLE.
  - dout = 8'h00, out_valid = 0, busy = 0, accept_count = 0.
  - Hold counter = 0.
- Handshake:
  - in_ready = enable && (state==IDLE || (state==HOLD && hold_cnt==0)).
  - Accept occurs when in_valid && in_ready at a rising edge.
  - din is sampled only on accept.
  - A valid code that is not accepted is not lost; the source must hold it until accepted.
- FSM states: IDLE, HOLD.
- IDLE:
  - dout = 0, out_valid = 0, busy = 0.
  - On accept: dout <= 8'b1 << din, out_valid <= 1, hold_cnt <= HOLD_CYCLES-1, state <= HOLD.
- HOLD:
  - dout is held constant; out_valid = 1, busy = 1.
  - When hold_cnt > 0: hold_cnt decrements each edge.
  - When hold_cnt == 0 and accept: load new one-hot code, reload hold_cnt, stay in HOLD. This is back-to-back with zero gap.
  - When hold_cnt == 0 and no accept: dout <= 0, out_valid <= 0, state <= IDLE.
- Latency: a code accepted at edge k drives dout during cycles k+1 through k+HOLD_CYCLES inclusive.
- HOLD_CYCLES == 1: hold_cnt loads 0, so each strobe lasts one cycle. Back-to-back accepts then give one new code per cycle.
- enable low:
  - in_ready = 0 combinationally.
  - If in HOLD, the next edge aborts: dout <= 0, out_valid <= 0, hold_cnt <= 0, state <= IDLE.
  - accept_count is unaffected.
- accept_count increments by 1 on every accept and wraps to 0 after 2^CNT_W-1. It is never cleared except by rst.
- dout is always either 8'h00 or exactly one bit set. It must never glitch to multi-hot on any edge.
- din is fully decoded (all 8 codes legal). There is no X-propagation requirement beyond clean reset values.
- Reset asserted mid-HOLD clears everything immediately. After rst deasserts, the first accept is possible at the first rising edge with enable and in_valid high.

Test Plan:
- Reset check: assert rst asynchronously between edges with HOLD active. Required: dout=8'h00, out_valid=0, busy=0, accept_count=0 before the next clk edge.
- Single decode, HOLD_CYCLES=4: enable=1, din=5, in_valid pulsed for one accepted cycle. Required: dout=8'b0010_0000 and out_valid=1 for exactly 4 cycles starting the cycle after accept, then 8'h00; accept_count=1.
- Exhaustive mapping: feed din=0..7 sequentially. Required: dout = 8'h01, 02, 04, 08, 10, 20, 40, 80 respectively, each held 4 cycles; accept_count=8.
- Back-to-back: in_valid held high with din=0, then din=7 at the first in_ready high during HOLD. Required: 8'h01 for 4 cycles immediately followed by 8'h80 for 4 cycles, no 8'h00 gap; in_ready=1 only on the last cycle of each hold.
- Enable gating: enable=0 with in_valid=1, din=3. Required: in_ready=0, dout stays 8'h00, no count change. Then drop enable during the 2nd cycle of HOLD for din=2. Required: dout=8'h00, busy=0 from the next edge.
- Edge cases:
  - HOLD_CYCLES=1 with continuous in_valid, din incrementing. Required: a new one-hot every cycle.
  - 256 accepts with CNT_W=8. Required: accept_count wraps to 0.
